muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 41 ++++
 rtl/muldiv_sign.sv | 20 ++
 rtl/muldiv_unit.sv | 189 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   op_e    - funct3 encodings of the M-extension operations
//   state_e - controller states
//   helpers - operand/result signedness decode from the opcode
package muldiv_pkg;

    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic logic is_div(input op_e op);
        return op[2];
    endfunction

    // REM/REMU return the remainder half of the divide result.
    function automatic logic is_rem(input op_e op);
        return op[2] & op[1];
    endfunction

    function automatic logic a_signed(input op_e op);
        return (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
    endfunction

    function automatic logic b_signed(input op_e op);
        return (op == OpMulh) || (op == OpDiv) || (op == OpRem);
    endfunction

endpackage

// File: rtl/muldiv_sign.sv
// muldiv_sign: conditional two's-complement negate.
//   i_val - value in
//   i_neg - 1: output -i_val, 0: pass through
//   o_val - value out
module muldiv_sign #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_val,
    input  logic            i_neg,
    output logic [XLEN-1:0] o_val
);

    always_comb begin
        o_val = i_val;
        if (i_neg) begin
            o_val = ~i_val + {{(XLEN-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M-style multiply/divide, one bit per cycle on operand magnitudes.
//   clk          - clock, rising edge
//   reset        - asynchronous active-low reset
//   start        - request, sampled only in IDLE/DONE
//   op           - funct3 operation select
//   src_a, src_b - rs1 / rs2 operands
//   flush        - synchronous abort of the operation in flight
//   busy         - operation in CALC
//   done         - one-cycle result-valid pulse
//   result       - last completed result, held between done pulses
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    state_e              r_state;
    op_e                 r_op;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*XLEN-1:0]   r_acc;    // mul: {partial hi, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]     r_opnd;   // multiplicand or divisor magnitude
    logic                r_neg;
    logic                r_busy;
    logic                r_done;
    logic [XLEN-1:0]     r_result;

    op_e                 w_op;
    logic                w_a_neg, w_b_neg, w_res_neg;
    logic [XLEN-1:0]     w_a_abs, w_b_abs;
    logic                w_div_zero, w_div_ovf, w_special;
    logic [XLEN-1:0]     w_special_res;
    logic                w_is_div;
    logic [XLEN:0]       w_add_a, w_add_b, w_sum;
    logic [2*XLEN-1:0]   w_acc_next, w_fix_in, w_fix_out;
    logic [XLEN-1:0]     w_final;

    // ---------------- acceptance-side decode ----------------
    always_comb begin
        w_op       = op_e'(op);
        w_a_neg    = a_signed(w_op) & src_a[XLEN-1];
        w_b_neg    = b_signed(w_op) & src_b[XLEN-1];
        w_div_zero = is_div(w_op) && (src_b == '0);
        w_div_ovf  = ((w_op == OpDiv) || (w_op == OpRem)) && (src_a == MinNeg) && (src_b == '1);
        w_special  = w_div_zero | w_div_ovf;
        if (w_div_zero) begin
            w_special_res = is_rem(w_op) ? src_a : '1;
        end else begin
            w_special_res = is_rem(w_op) ? '0 : src_a;
        end
        case (w_op)
            OpMulh, OpDiv:   w_res_neg = w_a_neg ^ w_b_neg;
            OpMulhsu, OpRem: w_res_neg = w_a_neg;
            default:         w_res_neg = 1'b0;
        endcase
    end

    muldiv_sign #(.XLEN(XLEN)) u_abs_a (
        .i_val (src_a),
        .i_neg (w_a_neg),
        .o_val (w_a_abs)
    );

    muldiv_sign #(.XLEN(XLEN)) u_abs_b (
        .i_val (src_b),
        .i_neg (w_b_neg),
        .o_val (w_b_abs)
    );

    // ---------------- shared iterative core ----------------
    // One (XLEN+1)-bit adder: conditional add for shift-add multiply, subtract for the
    // restoring-divide trial. A clear carry-out on the subtract means the trial fits.
    always_comb begin
        w_is_div = is_div(r_op);
        w_add_a  = w_is_div ? r_acc[2*XLEN-1:XLEN-1] : {1'b0, r_acc[2*XLEN-1:XLEN]};
        if (w_is_div) begin
            w_add_b = ~{1'b0, r_opnd};
        end else begin
            w_add_b = r_acc[0] ? {1'b0, r_opnd} : '0;
        end
        w_sum = w_add_a + w_add_b + {{XLEN{1'b0}}, w_is_div};

        if (!w_is_div) begin
            w_acc_next = {w_sum, r_acc[XLEN-1:1]};
        end else if (!w_sum[XLEN]) begin
            w_acc_next = {w_sum[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end else begin
            w_acc_next = {r_acc[2*XLEN-2:0], 1'b0};
        end

        // Divide results are zero-extended so a 2*XLEN negate also fixes XLEN-bit values.
        if (w_is_div) begin
            w_fix_in = {{XLEN{1'b0}},
                        is_rem(r_op) ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0]};
        end else begin
            w_fix_in = w_acc_next;
        end
    end

    muldiv_sign #(.XLEN(2*XLEN)) u_fix (
        .i_val (w_fix_in),
        .i_neg (r_neg),
        .o_val (w_fix_out)
    );

    always_comb begin
        if (w_is_div || (r_op == OpMul)) begin
            w_final = w_fix_out[XLEN-1:0];
        end else begin
            w_final = w_fix_out[2*XLEN-1:XLEN];
        end
    end

    // ---------------- controller ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= StIdle;
            r_op     <= OpMul;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    if (start && !flush) begin
                        r_op  <= w_op;
                        r_neg <= w_res_neg;
                        r_cnt <= '0;
                        if (w_special) begin
                            r_state  <= StDone;
                            r_done   <= 1'b1;
                            r_result <= w_special_res;
                        end else begin
                            r_state <= StCalc;
                            r_busy  <= 1'b1;
                            r_acc   <= {{XLEN{1'b0}}, is_div(w_op) ? w_a_abs : w_b_abs};
                            r_opnd  <= is_div(w_op) ? w_b_abs : w_a_abs;
                        end
                    end
                end
                StCalc: begin
                    if (flush) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(XLEN - 1)) begin
                            r_state  <= StDone;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_result <= w_final;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit (XLEN=32) against an
// arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          n_checks;
    int          n_errors;
    logic [31:0] last_exp;
    logic [31:0] specials [5];

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural result of each operation, straight from the arithmetic definitions.
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned p;
        int              ia;
        int              ib;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'd0;
        case (o)
            3'd0: begin p = ua * ub;            return p[31:0];  end
            3'd1: begin p = sa * sb;            return p[63:32]; end
            3'd2: begin p = sa * longint'(ub);  return p[63:32]; end
            3'd3: begin p = ua * ub;            return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Start-to-done latency: special divides finish in cycle 1, everything else in XLEN+1.
    function automatic int exp_latency(input logic [2:0] o, input logic [31:0] a,
                                       input logic [31:0] b);
        if (o >= 3'd4 && b == 32'd0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 15));
            2:       return 32'd0 - 32'($urandom_range(1, 15));
            default: return specials[$urandom_range(0, 4)];
        endcase
    endfunction

    // Issue one op in the current cycle (cycle 0) and follow it to its done pulse.
    // poke != 0 raises start with junk inputs in that CALC cycle; it must be ignored.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int poke, input string tag);
        int cyc;
        int bcnt;
        int lat;
        lat   = exp_latency(o, a, b);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        bcnt  = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) bcnt++;
            if (cyc == poke) begin
                start = 1'b1;
                op    = 3'($urandom);
                src_a = $urandom;
                src_b = $urandom;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(cyc), 64'(lat));
        check({tag, " busy_cycles"}, 64'(bcnt), 64'(lat - 1));
        check({tag, " result"}, result, exp);
        check({tag, " busy_at_done"}, busy, 1'b0);
        last_exp = exp;
    endtask

    task automatic hold_check(input string tag);
        start = 1'b0;
        repeat (3) tick();
        check({tag, " result_held"}, result, last_exp);
        check({tag, " done_low"}, done, 1'b0);
        check({tag, " busy_low"}, busy, 1'b0);
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic        saw_done;

        n_checks   = 0;
        n_errors   = 0;
        last_exp   = 32'd0;
        specials   = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        reset      = 1'b0;
        start      = 1'b0;
        flush      = 1'b0;
        op         = 3'd0;
        src_a      = 32'd0;
        src_b      = 32'd0;

        // Reset state
        #2;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset result", result, 32'd0);
        #10 reset = 1'b1;
        tick();

        // Directed, all back-to-back (each start lands in the previous DONE cycle)
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, "mul");
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu");
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, "mulh");
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu");
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, "div");
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, "rem");
        do_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, "divu_by0");
        do_op(3'd7, 32'd5, 32'd0, 32'd5, 0, "remu_by0");
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "div_ovf");
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, "rem_ovf");
        hold_check("idle");

        // Start during CALC is ignored
        do_op(3'd5, 32'd1000, 32'd7, 32'd142, 12, "poke");

        // Flush beats a simultaneous start while accepting
        flush = 1'b1;
        start = 1'b1;
        op    = 3'd0;
        src_a = 32'd3;
        src_b = 32'd3;
        tick();
        flush = 1'b0;
        start = 1'b0;
        check("flush_vs_start busy", busy, 1'b0);
        check("flush_vs_start done", done, 1'b0);
        check("flush_vs_start result", result, last_exp);

        // Flush in cycle 10 of a DIV
        op       = 3'd4;
        src_a    = $urandom;
        src_b    = 32'd3;
        start    = 1'b1;
        saw_done = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        if (done === 1'b1) saw_done = 1'b1;
        check("flush busy", busy, 1'b0);
        check("flush no_done", saw_done, 1'b0);
        check("flush result_kept", result, last_exp);
        a = $urandom;
        b = $urandom;
        do_op(3'd1, a, b, ref_model(3'd1, a, b), 0, "after_flush");

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            do_op(o, a, b, ref_model(o, a, b), (i % 5 == 0) ? $urandom_range(2, 30) : 0,
                  "rand");
            if (i % 8 == 0) hold_check("rand_idle");
        end

        // Asynchronous reset mid-CALC
        a = $urandom;
        b = 32'h1234_5678;
        op    = 3'd3;
        src_a = a;
        src_b = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        #1;
        check("async_reset busy", busy, 1'b0);
        check("async_reset done", done, 1'b0);
        check("async_reset result", result, 32'd0);
        #2 reset = 1'b1;
        last_exp = 32'd0;
        do_op(3'd3, 32'd3, 32'd5, 32'd0, 0, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
